decodificador_hamming_pipe: RTL
===============================

# decodificador_hamming_pipe

Parametrised, pipelined Hamming SECDED decoder with valid/ready handshakes and error statistics. It generalises the switch-driven 4-bit/8-bit correction chain to any data width and to a streaming interface. It accepts an extended-Hamming codeword per handshake and emits the corrected data word, error position and status two cycles later. Throughput is one word per cycle under back-pressure. It sits between any codeword source (switch sampler, UART receiver) and the LED/display stage.

## Interface
- `DATA_W`, 4: data bits per word, ≥ 2.
- `PAR_W`, derived: smallest p with 2^p ≥ DATA_W+p+1. Localparam, not overridable.
- `CW_W`, derived: DATA_W+PAR_W+1, the codeword width (8 for DATA_W=4).
- `CNT_W`, 16: width of each error counter.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, synchronous, active-low.
- `in_valid` in, 1: `in_palabra` holds a codeword.
- `in_ready` out, 1: the block accepts a codeword this cycle.
- `in_palabra` in, CW_W: received codeword. Bit 0 is overall parity; bit i (1..CW_W-1) is Hamming position i.
- `out_valid` out, 1: result valid.
- `out_ready` in, 1: sink accepts the result.
- `out_dato` out, DATA_W: corrected data. d0 is the lowest non-power-of-two position, ascending.
- `out_pos_error` out, PAR_W: syndrome, i.e. the flipped position (0 = none or bit 0).
- `out_corregido` out, 1: single error corrected.
- `out_doble_error` out, 1: uncorrectable error detected.
- `cnt_borrar` in, 1: synchronous clear of both counters.
- `cnt_corregidos` out, CNT_W: count of corrected words.
- `cnt_dobles` out, CNT_W: count of uncorrectable words.

## Operation
- **Stage 1 (S1), on input handshake** (`in_valid && in_ready`):
  - Register the codeword.
  - Register the syndrome s = XOR of indices i (1..CW_W-1) where bit i = 1.
  - Register the global parity g = XOR of all CW_W bits.
- **Stage 2 (S2)** decodes from S1 as follows:
  - s=0, g=0: no error. Data is extracted unchanged; both flags are 0.
  - s=0, g=1: bit 0 is in error. Data is unchanged, `out_corregido`=1, pos=0.
  - s≠0, g=1, s ≤ CW_W-1: bit s is inverted, then data is extracted; `out_corregido`=1, pos=s.
  - s≠0, g=1, s > CW_W-1 (shortened code): treated as uncorrectable. `out_doble_error`=1; data is extracted raw.
  - s≠0, g=0: double error. `out_doble_error`=1; data is extracted raw; pos=s.
- `out_corregido` and `out_doble_error` are never both 1.
- **Pipeline control:** each stage has its own valid bit.
  - A stage advances when it is empty or its downstream consumer takes the data.
  - `in_ready` = !s1_valid || (!s2_valid || out_ready). This is purely combinational from registers and `out_ready`. There is no skid buffer.
  - While `out_valid && !out_ready`, all outputs hold stable.
- **Counters** increment on the output handshake when the matching flag is set.
  - They saturate at all-ones (no wrap).
  - `cnt_borrar` has priority over a simultaneous increment; the result is 0.

## Timing
- Latency: input handshake in cycle n → `out_valid` in cycle n+2 with no back-pressure.
- Throughput: 1 word/cycle with `out_ready` held high.
- Reset (`rst_n`=0 at a clock edge): both valid bits are cleared and data registers go to 0.
  - Outputs: `out_valid`=0, `out_dato`=0, `out_pos_error`=0, `out_corregido`=0, `out_doble_error`=0.
  - Counters reset to 0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation: in-flight words are discarded and not counted.
- Stall: if S2 is full and `out_ready`=0, S1 may still fill once; `in_ready` then drops. When `out_ready` returns, both stages shift in the same cycle and `in_ready` rises in that cycle.
- Input and output handshakes in the same cycle are allowed when both stages are full (full-rate flow).

## Configuration
- `HAMMING_CONTADORES_EN` defined: the counters and `cnt_borrar` logic are built as described.
- `HAMMING_CONTADORES_EN` undefined: no counter flops are built.
  - `cnt_corregidos` and `cnt_dobles` are tied to 0.
  - `cnt_borrar` is ignored.
  - Decode behaviour and timing are unchanged.

## Structure
- Shared package `hamming_pkg`:
  - function computing PAR_W from DATA_W;
  - function mapping data index → codeword position;
  - status typedef `estado_t` {NINGUNO, CORREGIDO, DOBLE}.
- One sub-module `hamming_sindrome` (combinational): codeword → {s, g}. It is reused by future encoder checks.
- Pipeline, correction and counters live in the top block.

## Test plan
- DATA_W=4, send 8'hAA, out_ready=1: after 2 cycles `out_dato`=4'hB, pos=0, both flags 0, counters unchanged.
- Send 8'h8A (bit 5 flipped): `out_dato`=4'hB, pos=5, `out_corregido`=1, `cnt_corregidos`=1.
- Send 8'hAB (bit 0 flipped): `out_dato`=4'hB, pos=0, `out_corregido`=1.
- Send 8'hCA (bits 5 and 6 flipped): `out_doble_error`=1, `out_dato`=4'hD, pos=3, `cnt_dobles`=1.
- Stream 4 back-to-back words with `out_ready`=0 for cycles 3–5:
  - `in_ready` falls after S1 fills;
  - outputs are stable during the stall;
  - all 4 results arrive in order with no loss or duplication.
- Apply rst_n=0 for one cycle with 2 words in flight: `out_valid`=0 next cycle, counters read 0, no late outputs appear.
- Repeat with the macro undefined: counters read 0 throughout.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SECDED types and width/position helpers
package hamming_pkg;

  typedef enum logic [1:0] {NINGUNO, CORREGIDO, DOBLE} estado_t;

  // Smallest p with 2^p >= data_w + p + 1
  function automatic int calc_par_w(input int data_w);
    calc_par_w = 0;
    for (int q = 30; q >= 1; q--) begin
      if ((1 << q) >= data_w + q + 1) calc_par_w = q;
    end
  endfunction

  // Codeword position of data bit idx: idx-th non-power-of-two position from 3 up
  function automatic int data_pos(input int idx);
    int cnt;
    data_pos = 0;
    cnt = 0;
    for (int p = 3; p < idx + 40; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) data_pos = p;
        cnt++;
      end
    end
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// rtl/hamming_sindrome.sv - combinational syndrome and global parity of a codeword
module hamming_sindrome #(
  parameter int CW_W  = 8,
  parameter int PAR_W = 3
) (
  input  logic [CW_W-1:0]  palabra,
  output logic [PAR_W-1:0] sindrome,
  output logic             paridad
);

  // Syndrome is the XOR of the indices of all set bits above overall parity
  always_comb begin
    sindrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (palabra[i]) sindrome = sindrome ^ PAR_W'(i);
    end
  end

  assign paridad = ^palabra;

endmodule

// File: rtl/decodificador_hamming_pipe.sv
// rtl/decodificador_hamming_pipe.sv - two-stage SECDED decoder; error counters built when HAMMING_CONTADORES_EN is defined
module decodificador_hamming_pipe
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_palabra,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dato,
  output logic [PAR_W-1:0]  out_pos_error,
  output logic              out_corregido,
  output logic              out_doble_error,
  input  logic              cnt_borrar,
  output logic [CNT_W-1:0]  cnt_corregidos,
  output logic [CNT_W-1:0]  cnt_dobles
);

  logic [PAR_W-1:0]  sind_c;
  logic              par_c;

  logic              s1_valid;
  logic [CW_W-1:0]   s1_palabra;
  logic [PAR_W-1:0]  s1_sind;
  logic              s1_par;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_dato;
  logic [PAR_W-1:0]  s2_pos;
  estado_t           s2_estado;

  logic [CW_W-1:0]   fijo_c;
  logic [DATA_W-1:0] dato_c;
  estado_t           estado_c;

  logic              s2_adv;
  logic              s1_adv;

  hamming_sindrome #(.CW_W(CW_W), .PAR_W(PAR_W)) u_sindrome (
    .palabra  (in_palabra),
    .sindrome (sind_c),
    .paridad  (par_c)
  );

  // No skid buffer: readiness ripples straight back from out_ready
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 captures the codeword with its syndrome and parity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_palabra <= '0;
      s1_sind    <= '0;
      s1_par     <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_palabra <= in_palabra;
        s1_sind    <= sind_c;
        s1_par     <= par_c;
      end
    end
  end

  // Classify the error and flip the addressed bit when it is correctable
  always_comb begin
    fijo_c   = s1_palabra;
    estado_c = NINGUNO;
    if (s1_sind == '0) begin
      if (s1_par) estado_c = CORREGIDO;
    end else if (s1_par) begin
      if (s1_sind <= PAR_W'(CW_W - 1)) begin
        fijo_c[s1_sind] = ~s1_palabra[s1_sind];
        estado_c        = CORREGIDO;
      end else begin
        estado_c = DOBLE;
      end
    end else begin
      estado_c = DOBLE;
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extrae
    localparam int POS = data_pos(k);
    assign dato_c[k] = fijo_c[POS];
  end

  // Stage 2 holds the decoded result until the sink takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_dato   <= '0;
      s2_pos    <= '0;
      s2_estado <= NINGUNO;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dato   <= dato_c;
        s2_pos    <= s1_sind;
        s2_estado <= estado_c;
      end
    end
  end

  assign out_valid       = s2_valid;
  assign out_dato        = s2_dato;
  assign out_pos_error   = s2_pos;
  assign out_corregido   = (s2_estado == CORREGIDO);
  assign out_doble_error = (s2_estado == DOBLE);

`ifdef HAMMING_CONTADORES_EN
  logic [CNT_W-1:0] corr_q;
  logic [CNT_W-1:0] dobl_q;
  logic             out_hs;

  assign out_hs = s2_valid && out_ready;

  // Saturating counters on the output handshake; clear beats increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_borrar) begin
      corr_q <= '0;
      dobl_q <= '0;
    end else if (out_hs) begin
      if (s2_estado == CORREGIDO && corr_q != '1) corr_q <= corr_q + CNT_W'(1);
      if (s2_estado == DOBLE && dobl_q != '1) dobl_q <= dobl_q + CNT_W'(1);
    end
  end

  assign cnt_corregidos = corr_q;
  assign cnt_dobles     = dobl_q;
`else
  logic unused_borrar;
  assign unused_borrar  = cnt_borrar;
  assign cnt_corregidos = '0;
  assign cnt_dobles     = '0;
`endif

endmodule
